// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller.
// Stage indices match the index of the pipeline register that feeds that stage.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    localparam logic [2:0] STG_IF  = 3'd0;
    localparam logic [2:0] STG_ID  = 3'd1;
    localparam logic [2:0] STG_EX  = 3'd2;
    localparam logic [2:0] STG_MEM = 3'd3;
    localparam logic [2:0] STG_WB  = 3'd4;

    localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipe_ctrl_stall_prio.sv
// Picks the latest pipeline stage that requests a stall (mem > ex > id > if).
module stall_prio
    import pipe_ctrl_pkg::*;
(
    input  logic       stallreq_if,
    input  logic       stallreq_id,
    input  logic       stallreq_ex,
    input  logic       stallreq_mem,
    output logic       stall_vld,
    output logic [2:0] stall_stage
);

    always_comb begin
        stall_vld   = 1'b1;
        stall_stage = STG_IF;
        if (stallreq_mem) begin
            stall_stage = STG_MEM;
        end else if (stallreq_ex) begin
            stall_stage = STG_EX;
        end else if (stallreq_id) begin
            stall_stage = STG_ID;
        end else if (stallreq_if) begin
            stall_stage = STG_IF;
        end else begin
            stall_vld = 1'b0;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: stall enables, bubbles, flush and PC redirect.
// Only state, new_pc and stall_cnt are registered; all controls decode from state and inputs.
//
// state       | meaning
// ST_RUN      | normal flow, stalls honoured, exceptions accepted
// ST_DRAIN    | exception accepted, waiting for outstanding fetch to finish
// ST_REDIRECT | one-cycle PC redirect pulse to the fetch unit
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        except_valid,
    input  logic [31:0] except_pc,
    input  logic        fetch_busy,
    output logic        en_pc,
    output logic        en_if_id,
    output logic        en_id_ex,
    output logic        en_ex_mem,
    output logic        en_mem_wb,
    output logic        bubble_id_ex,
    output logic        bubble_ex_mem,
    output logic        bubble_mem_wb,
    output logic        flush,
    output logic        new_pc_valid,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cnt
);

    state_e      state_q, state_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stall_vld;
    logic [2:0]  stall_stage;
    logic        stall_count_en;

    stall_prio u_stall_prio (
        .stallreq_if (stallreq_if),
        .stallreq_id (stallreq_id),
        .stallreq_ex (stallreq_ex),
        .stallreq_mem(stallreq_mem),
        .stall_vld   (stall_vld),
        .stall_stage (stall_stage)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            new_pc_q    <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            new_pc_q    <= new_pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (except_valid) begin
                    state_d = fetch_busy ? ST_DRAIN : ST_REDIRECT;
                end
            end
            ST_DRAIN: begin
                if (!fetch_busy) begin
                    state_d = ST_REDIRECT;
                end
            end
            ST_REDIRECT: state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase
    end

    assign stall_count_en = (state_q == ST_RUN) && !except_valid && stall_vld;

    always_comb begin
        new_pc_d    = new_pc_q;
        stall_cnt_d = stall_cnt_q;
        if ((state_q == ST_RUN) && except_valid) begin
            new_pc_d = except_pc;
        end
        if (stall_count_en && (stall_cnt_q != STALL_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall at stage k freezes every register up to the one feeding k and bubbles the next one.
    always_comb begin
        flush         = 1'b0;
        new_pc_valid  = 1'b0;
        en_pc         = 1'b1;
        en_if_id      = 1'b1;
        en_id_ex      = 1'b1;
        en_ex_mem     = 1'b1;
        en_mem_wb     = 1'b1;
        bubble_id_ex  = 1'b0;
        bubble_ex_mem = 1'b0;
        bubble_mem_wb = 1'b0;
        if (rst || (state_q == ST_DRAIN) || ((state_q == ST_RUN) && except_valid)) begin
            flush     = 1'b1;
            en_pc     = 1'b0;
            en_if_id  = 1'b0;
            en_id_ex  = 1'b0;
            en_ex_mem = 1'b0;
            en_mem_wb = 1'b0;
        end else if (state_q == ST_REDIRECT) begin
            new_pc_valid = 1'b1;
        end else if (state_q == ST_RUN && stall_vld) begin
            en_pc         = 1'b0;
            en_if_id      = (stall_stage < STG_ID);
            en_id_ex      = (stall_stage < STG_EX);
            en_ex_mem     = (stall_stage < STG_MEM);
            en_mem_wb     = (stall_stage < STG_WB);
            bubble_id_ex  = (stall_stage == STG_ID);
            bubble_ex_mem = (stall_stage == STG_EX);
            bubble_mem_wb = (stall_stage == STG_MEM);
        end else if (state_q != ST_RUN) begin
            flush     = 1'b1;
            en_pc     = 1'b0;
            en_if_id  = 1'b0;
            en_id_ex  = 1'b0;
            en_ex_mem = 1'b0;
            en_mem_wb = 1'b0;
        end
    end

    assign new_pc    = new_pc_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: behavioural model compared every cycle plus directed literals.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        except_valid;
    logic [31:0] except_pc;
    logic        fetch_busy;
    logic        en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
    logic        bubble_id_ex, bubble_ex_mem, bubble_mem_wb;
    logic        flush, new_pc_valid;
    logic [31:0] new_pc, stall_cnt;

    int n_pass  = 0;
    int n_total = 0;

    bit          m_drain = 1'b0;
    bit          m_redir = 1'b0;
    logic [31:0] m_cnt   = 32'd0;
    logic [31:0] m_pc    = 32'd0;
    bit          preload = 1'b0;

    logic [9:0]  ctl_act;

    pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .except_valid (except_valid),
        .except_pc    (except_pc),
        .fetch_busy   (fetch_busy),
        .en_pc        (en_pc),
        .en_if_id     (en_if_id),
        .en_id_ex     (en_id_ex),
        .en_ex_mem    (en_ex_mem),
        .en_mem_wb    (en_mem_wb),
        .bubble_id_ex (bubble_id_ex),
        .bubble_ex_mem(bubble_ex_mem),
        .bubble_mem_wb(bubble_mem_wb),
        .flush        (flush),
        .new_pc_valid (new_pc_valid),
        .new_pc       (new_pc),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    assign ctl_act = {flush, new_pc_valid, en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
                      bubble_id_ex, bubble_ex_mem, bubble_mem_wb};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Expected {flush, new_pc_valid, en[pc..mem_wb], bubble[id_ex..mem_wb]} from the rules.
    function automatic logic [9:0] exp_ctl();
        logic [3:0] req;
        logic [4:0] en;
        logic [2:0] bub;
        int         k;
        req = {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if};
        if (rst || m_drain || (!m_redir && except_valid)) return 10'b10_00000_000;
        if (m_redir) return 10'b01_11111_000;
        k = -1;
        for (int s = 0; s < 4; s++) if (req[s]) k = s;
        en  = 5'b11111;
        bub = 3'b000;
        if (k >= 0) begin
            for (int r = 0; r < 5; r++) en[4-r] = (r > k);
            if (k >= 1) bub[3-k] = 1'b1;
        end
        return {2'b00, en, bub};
    endfunction

    initial begin
        logic prev_npv;
        prev_npv = 1'b0;
        forever begin
            @(negedge clk);
            check("ctl", {22'd0, ctl_act}, {22'd0, exp_ctl()});
            check("stall_cnt", stall_cnt, m_cnt);
            check("new_pc", new_pc, m_pc);
            if (prev_npv) check("npv_single_pulse", {31'd0, new_pc_valid}, 32'd0);
            prev_npv = new_pc_valid;
            if (rst) begin
                m_drain = 1'b0; m_redir = 1'b0; m_cnt = 32'd0; m_pc = 32'd0;
            end else if (m_redir) begin
                m_redir = 1'b0;
            end else if (m_drain) begin
                if (!fetch_busy) begin m_drain = 1'b0; m_redir = 1'b1; end
            end else if (except_valid) begin
                m_pc = except_pc;
                if (fetch_busy) m_drain = 1'b1; else m_redir = 1'b1;
            end else if (stallreq_if | stallreq_id | stallreq_ex | stallreq_mem) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            end
            if (preload) m_cnt = 32'hFFFF_FFFE;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int npv_idx, fl_cnt, npv_seen;
        logic [31:0] pc_at;
        rst = 1'b1;
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b0000;
        except_valid = 1'b0; except_pc = 32'd0; fetch_busy = 1'b0;
        repeat (3) tick();
        check("rst_ctl", {22'd0, ctl_act}, {22'd0, 10'b10_00000_000});
        rst = 1'b0;
        #1;
        check("run_idle_ctl", {22'd0, ctl_act}, {22'd0, 10'b00_11111_000});
        check("cnt_after_rst", stall_cnt, 32'd0);

        // EX stall held three cycles
        stallreq_ex = 1'b1;
        #1;
        check("ex_stall_ctl", {22'd0, ctl_act}, {22'd0, 10'b00_00011_010});
        repeat (3) tick();
        check("cnt_after_ex3", stall_cnt, 32'd3);

        // IF + MEM together: only MEM honoured
        stallreq_ex = 1'b0; stallreq_if = 1'b1; stallreq_mem = 1'b1;
        #1;
        check("mem_over_if_ctl", {22'd0, ctl_act}, {22'd0, 10'b00_00001_001});
        tick();
        check("cnt_after_mem", stall_cnt, 32'd4);
        stallreq_mem = 1'b0;
        #1;
        check("if_stall_ctl", {22'd0, ctl_act}, {22'd0, 10'b00_01111_000});
        stallreq_if = 1'b0; stallreq_id = 1'b1;
        #1;
        check("id_stall_ctl", {22'd0, ctl_act}, {22'd0, 10'b00_00111_100});
        tick();
        stallreq_id = 1'b0;

        // Exception with no outstanding fetch
        except_valid = 1'b1; except_pc = 32'hBFC0_0380; stallreq_ex = 1'b1;
        #1;
        check("exc_flush", {31'd0, flush}, 32'd1);
        tick();
        except_valid = 1'b0; except_pc = 32'h0;
        #1;
        check("redir_npv", {31'd0, new_pc_valid}, 32'd1);
        check("redir_pc", new_pc, 32'hBFC0_0380);
        check("redir_ctl", {22'd0, ctl_act}, {22'd0, 10'b01_11111_000});
        tick();
        check("back_to_run_npv", {31'd0, new_pc_valid}, 32'd0);
        stallreq_ex = 1'b0;
        tick();

        // Exception while fetch outstanding for four cycles
        npv_idx = -1; fl_cnt = 0; pc_at = 32'd0;
        for (int i = 0; i < 12; i++) begin
            fetch_busy   = (i <= 3);
            except_valid = (i == 0 || i == 2);
            except_pc    = (i == 0) ? 32'h8000_0180 : 32'h1234_5678;
            #1;
            if (new_pc_valid) begin
                npv_idx = i; pc_at = new_pc;
                break;
            end
            if (flush) fl_cnt++;
            tick();
        end
        check("drain_npv_cycle", npv_idx, 32'd5);
        check("drain_flush_cycles", fl_cnt, 32'd5);
        check("drain_pc", pc_at, 32'h8000_0180);
        except_valid = 1'b0; fetch_busy = 1'b0; except_pc = 32'd0;
        tick();

        // Saturation from a preloaded count
        force dut.stall_cnt_d = 32'hFFFF_FFFE;
        preload = 1'b1;
        tick();
        release dut.stall_cnt_d;
        preload = 1'b0;
        check("preload_cnt", stall_cnt, 32'hFFFF_FFFE);
        stallreq_mem = 1'b1;
        repeat (3) tick();
        check("cnt_saturated", stall_cnt, 32'hFFFF_FFFF);
        stallreq_mem = 1'b0;
        tick();

        // Reset while draining aborts the redirect
        except_valid = 1'b1; except_pc = 32'hDEAD_BEEC; fetch_busy = 1'b1;
        tick();
        except_valid = 1'b0; rst = 1'b1; fetch_busy = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("rst_drain_cnt", stall_cnt, 32'd0);
        check("rst_drain_ctl", {22'd0, ctl_act}, {22'd0, 10'b00_11111_000});
        npv_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (new_pc_valid) npv_seen++;
        end
        check("rst_drain_no_npv", npv_seen, 32'd0);

        // Reset during the redirect cycle suppresses the pulse
        except_valid = 1'b1; except_pc = 32'h0000_1000;
        tick();
        except_valid = 1'b0; rst = 1'b1;
        #1;
        check("rst_redir_npv", {31'd0, new_pc_valid}, 32'd0);
        tick();
        rst = 1'b0;
        npv_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (new_pc_valid) npv_seen++;
        end
        check("rst_redir_no_npv", npv_seen, 32'd0);

        // Sweep all stall request combinations
        for (int v = 0; v < 16; v++) begin
            {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'(v);
            tick();
        end
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b0000;
        tick();
        check("sweep_cnt", stall_cnt, 32'd15);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have the port clk, input, 1 bit: pipeline clock; all state updates on its rising edge.
REQ-002 SHALL have the port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have the ports stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, inputs, 1 bit each: per-stage stall requests.
REQ-004 SHALL have the port except_valid, input, 1 bit: MEM stage commits an exception or eret this cycle.
REQ-005 SHALL have the port except_pc, input, 32 bits: handler or EPC target, valid with except_valid.
REQ-006 SHALL have the port fetch_busy, input, 1 bit: a multicycle instruction fetch is outstanding.
REQ-007 SHALL have the ports en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb, outputs, 1 bit each: per-register load enables.
REQ-008 SHALL have the ports bubble_id_ex, bubble_ex_mem, bubble_mem_wb, outputs, 1 bit each: load a NOP into that register this cycle.
REQ-009 SHALL have the port flush, output, 1 bit: clear all pipeline registers.
REQ-010 SHALL have the ports new_pc_valid, output, 1 bit, and new_pc, output, 32 bits: PC redirect to the fetch unit.
REQ-011 SHALL have the port stall_cnt, output, 32 bits: count of stalled cycles.

Function
REQ-012 SHALL implement an FSM with the states RUN, DRAIN and REDIRECT.
REQ-013 In RUN with except_valid=0, SHALL take only the latest-stage stall request, in priority order mem > ex > id > if.
REQ-014 When the stall is at stage k, SHALL drive en low for the PC and every register up to and including the one feeding stage k, drive en high for the later registers, and assert bubble on the register directly after stage k. Combinational, zero latency.
REQ-015 stallreq_mem SHALL produce en_pc=en_if_id=en_id_ex=en_ex_mem=0, bubble_mem_wb=1 and en_mem_wb=1.
REQ-016 With no stall and no exception in RUN, SHALL drive all en=1, all bubble=0, flush=0 and new_pc_valid=0.
REQ-017 A bubble output SHALL be asserted only together with the matching en=1.
REQ-018 except_valid=1 in RUN SHALL:
  - override every stall request;
  - drive flush=1 and all en=0 in the same cycle;
  - latch except_pc into new_pc;
  - go to DRAIN if fetch_busy=1, otherwise to REDIRECT.
REQ-019 DRAIN SHALL drive flush=1, all en=0 and new_pc_valid=0.
REQ-020 DRAIN SHALL stay in DRAIN while fetch_busy=1 and go to REDIRECT in the cycle after fetch_busy is sampled 0.
REQ-021 REDIRECT SHALL last one cycle, drive new_pc_valid=1, en_pc=1, all other en=1 and flush=0, then return to RUN.
REQ-022 In REDIRECT, the stall inputs and except_valid SHALL be ignored.
REQ-023 except_valid SHALL be ignored in DRAIN and REDIRECT; new_pc SHALL hold its latched value until the next accepted exception.
REQ-024 stall_cnt SHALL increment by 1 per RUN cycle in which any stall request is honoured and except_valid=0.
REQ-025 stall_cnt SHALL saturate at 32'hFFFF_FFFF and SHALL not count DRAIN cycles.
REQ-026 new_pc_valid SHALL never be high for two consecutive cycles.

Reset
REQ-027 rst=1 SHALL force state RUN, new_pc=0 and stall_cnt=0.
REQ-028 While rst=1, SHALL drive flush=1, all en=0, all bubble=0 and new_pc_valid=0.
REQ-029 rst asserted in DRAIN or REDIRECT SHALL abort the redirect; no new_pc_valid pulse follows.

Structure
REQ-030 SHALL place the FSM state typedef and the stage index constants (IF, ID, EX, MEM, WB) in the shared package pipe_ctrl_pkg.
REQ-031 SHALL put the stall priority resolution in one combinational sub-module, stall_prio, returning the stage index of the honoured stall.
REQ-032 SHALL register only the state, new_pc and stall_cnt; all enables, bubbles and flush are decoded from state and inputs.

Verification
REQ-033 stallreq_ex=1 for 3 cycles in RUN -> en_pc=en_if_id=en_id_ex=0, en_ex_mem=1, bubble_ex_mem=1 for those 3 cycles; stall_cnt 0->3.
REQ-034 stallreq_if=1 and stallreq_mem=1 together -> only the mem pattern (REQ-015) appears; stall_cnt +1.
REQ-035 except_valid=1, except_pc=32'hBFC0_0380, fetch_busy=0 at cycle N -> flush=1 at N; new_pc_valid=1 with new_pc=32'hBFC0_0380 at N+1; RUN at N+2.
REQ-036 Same stimulus with fetch_busy=1 for cycles N..N+3 -> flush=1 at N..N+4 (fetch_busy sampled 0 at N+4); new_pc_valid only at N+5.
REQ-037 stall_cnt preloaded to 32'hFFFF_FFFE, stall held 3 cycles -> stall_cnt ends at 32'hFFFF_FFFF.
REQ-038 rst=1 in DRAIN -> next cycle state RUN, stall_cnt=0, and no new_pc_valid pulse ever follows.
